// File: rtl/spm_pkg.sv
// Shared definitions for the scratchpad dual-port RAM: default geometry,
// clear-sweep state encoding and the byte-lane merge helper.
package spm_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 4096;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef logic [0:0] clr_state_t;
    localparam clr_state_t CLEAR = 1'b0;
    localparam clr_state_t RUN   = 1'b1;

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/spm_dpram_port.sv
// One access port of the scratchpad: request acceptance, registered read data
// with a valid pulse, and forwarding of the other port's same-cycle write.
module spm_dpram_port
    import spm_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int ADDR_W = 12,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_word,
    input  logic              peer_wr,
    input  logic [ADDR_W-1:0] peer_addr,
    input  logic [DATA_W-1:0] peer_wdata,
    input  logic [BE_W-1:0]   peer_be,
    output logic              wr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic              accept;
    logic              rd;
    logic [BE_W-1:0]   merge_be;
    logic [DATA_W-1:0] rd_word;

    assign accept = req & ready;
    assign wr     = accept & we;
    assign rd     = accept & ~we;

    // A read that races a write from the other port returns the post-write word.
    always_comb begin
        merge_be = '0;
        if (peer_wr && (peer_addr == addr)) merge_be = peer_be;
        rd_word = DATA_W'(byte_merge(MAX_DATA_W'(mem_word),
                                     MAX_DATA_W'(peer_wdata),
                                     MAX_BE_W'(merge_be)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd) rdata <= rd_word;
        end
    end

endmodule

// File: rtl/spm_dpram_ctrl.sv
// True dual-port scratchpad with byte enables and port-A-wins write arbitration.
// Define SPM_CLEAR_EN to zero the whole array after every reset (busy while sweeping).
module spm_dpram_ctrl
    import spm_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [BE_W-1:0]   a_be,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [BE_W-1:0]   b_be,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              busy,
    output logic              collision
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              a_wr;
    logic              b_wr;

`ifdef SPM_CLEAR_EN
    clr_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= RUN;
        end
    end

    assign busy   = (state == CLEAR);
    assign clr_we = busy & ~reset;
`else
    assign busy = 1'b0;
`endif

    assign a_ready = ~(busy | reset);
    assign b_ready = ~(busy | reset);

    spm_dpram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .clk        (clk),
        .reset      (reset),
        .ready      (a_ready),
        .req        (a_req),
        .we         (a_we),
        .addr       (a_addr),
        .mem_word   (mem[a_addr]),
        .peer_wr    (b_wr),
        .peer_addr  (b_addr),
        .peer_wdata (b_wdata),
        .peer_be    (b_be),
        .wr         (a_wr),
        .rdata      (a_rdata),
        .rvalid     (a_rvalid)
    );

    spm_dpram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .clk        (clk),
        .reset      (reset),
        .ready      (b_ready),
        .req        (b_req),
        .we         (b_we),
        .addr       (b_addr),
        .mem_word   (mem[b_addr]),
        .peer_wr    (a_wr),
        .peer_addr  (a_addr),
        .peer_wdata (a_wdata),
        .peer_be    (a_be),
        .wr         (b_wr),
        .rdata      (b_rdata),
        .rvalid     (b_rvalid)
    );

    // Port A lanes are assigned last so they override B on shared bytes.
    always_ff @(posedge clk) begin
`ifdef SPM_CLEAR_EN
        if (clr_we) mem[clr_cnt] <= '0;
`endif
        for (int i = 0; i < BE_W; i++) begin
            if (b_wr && b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
        for (int i = 0; i < BE_W; i++) begin
            if (a_wr && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) collision <= 1'b0;
        else       collision <= a_wr & b_wr & (a_addr == b_addr) & (|(a_be & b_be));
    end

endmodule

// File: tb/tb_spm_dpram_ctrl.sv
// Directed self-checking bench for spm_dpram_ctrl (DATA_W = 32, DEPTH = 16);
// covers both the default build and the SPM_CLEAR_EN build.
module tb_spm_dpram_ctrl;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_be, b_be, a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ready, b_ready, a_rvalid, b_rvalid, busy, collision;
    logic [31:0] a_rdata, b_rdata;

    int   nAsserts;
    int   nFails;
    int   cycles;
    logic sawValid;

`ifdef SPM_CLEAR_EN
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    spm_dpram_ctrl #(.DATA_W(32), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_be      (a_be),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ready   (a_ready),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_be      (b_be),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ready   (b_ready),
        .b_rdata   (b_rdata),
        .b_rvalid  (b_rvalid),
        .busy      (busy),
        .collision (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 4'd0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 4'd0; b_wdata = 32'h0;
    endtask

    // Drives both ports, then advances one clock and samples 1 ns after the edge.
    task automatic applyStimulus(
        input logic ar, input logic aw, input logic [3:0] abe, input logic [3:0] aad, input logic [31:0] awd,
        input logic br, input logic bw, input logic [3:0] bbe, input logic [3:0] bad, input logic [31:0] bwd);
        a_req = ar; a_we = aw; a_be = abe; a_addr = aad; a_wdata = awd;
        b_req = br; b_we = bw; b_be = bbe; b_addr = bad; b_wdata = bwd;
        @(posedge clk);
        #1;
    endtask

    task automatic waitSweep(output int n, output logic saw);
        n   = 0;
        saw = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) saw = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nAsserts = 0;
        nFails   = 0;
        reset    = 1'b1;
        idleInputs();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_a_rdata", a_rdata, 32'h0);
        checkOutput("rst_b_rdata", b_rdata, 32'h0);
        checkFlag("rst_a_rvalid", a_rvalid, 1'b0);
        checkFlag("rst_b_rvalid", b_rvalid, 1'b0);
        checkFlag("rst_collision", collision, 1'b0);
        checkFlag("rst_busy", busy, EXP_BUSY_RST);

`ifdef SPM_CLEAR_EN
        checkFlag("rst_a_ready", a_ready, 1'b0);
        a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 4'd2; a_wdata = 32'hFFFFFFFF;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        reset = 1'b0;
        waitSweep(cycles, sawValid);
        idleInputs();
        checkOutput("sweep_len", 32'(cycles), 32'd16);
        checkFlag("sweep_no_rvalid", sawValid, 1'b0);
        checkFlag("sweep_a_ready", a_ready, 1'b1);
        checkFlag("sweep_b_ready", b_ready, 1'b1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, i[3:0], 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
            checkOutput("clr_read", a_rdata, 32'h0);
            checkFlag("clr_rvalid", a_rvalid, 1'b1);
        end
`else
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkFlag("run_a_ready", a_ready, 1'b1);
        checkFlag("run_b_ready", b_ready, 1'b1);
`endif

        // Full write then low-byte write on address 5, read back on B
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkFlag("wr_no_rvalid", a_rvalid, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'h1, 4'd5, 32'h000000AA, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        checkFlag("be_rvalid", b_rvalid, 1'b1);
        checkOutput("be_rdata", b_rdata, 32'hDEADBEAA);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkFlag("rvalid_pulse", b_rvalid, 1'b0);
        checkOutput("rdata_hold", b_rdata, 32'hDEADBEAA);

        // A reads while B writes low half of address 3
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b1, 4'hF, 4'd3, 32'h11223344);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b1, 1'b1, 4'h3, 4'd3, 32'hAABBCCDD);
        checkOutput("rw_merge", a_rdata, 32'h1122CCDD);
        checkFlag("rw_a_rvalid", a_rvalid, 1'b1);
        checkFlag("rw_b_rvalid", b_rvalid, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkOutput("rw_commit", a_rdata, 32'h1122CCDD);

        // Overlapping same-address writes on zeroed address 7
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd7, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        applyStimulus(1'b1, 1'b1, 4'h6, 4'd7, 32'h11111111, 1'b1, 1'b1, 4'hC, 4'd7, 32'h22222222);
        checkFlag("coll_pulse", collision, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        checkFlag("coll_clear", collision, 1'b0);
        checkOutput("coll_arb", b_rdata, 32'h22111100);

        // Same address, disjoint byte enables: no collision
        applyStimulus(1'b1, 1'b1, 4'h3, 4'd8, 32'h12345678, 1'b1, 1'b1, 4'hC, 4'd8, 32'h9ABCDEF0);
        checkFlag("nocoll", collision, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd8, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkOutput("disjoint_merge", a_rdata, 32'h9ABC5678);

        // Back-to-back writes then crossed reads on both ports
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd9, 32'h01010101, 1'b1, 1'b1, 4'hF, 4'd10, 32'h02020202);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd10, 32'h0, 1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        checkOutput("dual_a_rdata", a_rdata, 32'h02020202);
        checkOutput("dual_b_rdata", b_rdata, 32'h01010101);
        checkFlag("dual_a_rvalid", a_rvalid, 1'b1);
        checkFlag("dual_b_rvalid", b_rvalid, 1'b1);

        // be = 0 write leaves the word unchanged
        applyStimulus(1'b1, 1'b1, 4'h0, 4'd9, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd9, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkOutput("be_zero", a_rdata, 32'h01010101);

        // B reads while A writes the upper half of address 10
        applyStimulus(1'b1, 1'b1, 4'hC, 4'd10, 32'hFFFF0000, 1'b1, 1'b0, 4'h0, 4'd10, 32'h0);
        checkOutput("wr_merge_b", b_rdata, 32'hFFFF0202);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);

        // Asynchronous reset clears the read registers without a clock edge
        reset = 1'b1;
        #1;
        checkOutput("async_a_rdata", a_rdata, 32'h0);
        checkOutput("async_b_rdata", b_rdata, 32'h0);
        checkFlag("async_busy", busy, EXP_BUSY_RST);

`ifdef SPM_CLEAR_EN
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkFlag("mid_sweep_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        checkFlag("abort_busy", busy, 1'b1);
        checkFlag("abort_ready", a_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitSweep(cycles, sawValid);
        checkOutput("resweep_len", 32'(cycles), 32'd16);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkOutput("resweep_zero", a_rdata, 32'h0);
`else
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkOutput("mem_survives_rst", a_rdata, 32'hDEADBEAA);
`endif

        idleInputs();
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/spm_dpram_ctrl.md
# spm_dpram_ctrl

Parametrised, single-clock, true dual-port scratchpad memory with per-byte write enables, request/ready handshakes, deterministic cross-port collision resolution and an optional post-reset clear sweep. It replaces the fixed-width SPM dual-port RAM between the CPU instruction-fetch port (A) and the memory-access/bus port (B). It is generalised in data width and depth and adds byte writes, read-valid signalling and defined same-cycle write/write behaviour.

## Interface
- DATA_W, 32, word width in bits; multiple of 8.
- DEPTH, 4096, number of words; power of two, ≥ 2.
- ADDR_W, $clog2(DEPTH), word-address width; derived, not overridden.
- BE_W, DATA_W/8, byte-enable width; derived.

- clk  in  1  sole clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req / b_req  in  1  request strobe for the port.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_be / b_be  in  BE_W  byte enables for writes; ignored on reads.
- a_addr / b_addr  in  ADDR_W  word address.
- a_wdata / b_wdata  in  DATA_W  write data.
- a_ready / b_ready  out  1  port accepts requests this cycle.
- a_rdata / b_rdata  out  DATA_W  read data, registered.
- a_rvalid / b_rvalid  out  1  one-cycle pulse: rdata holds the result of an accepted read.
- busy  out  1  clear sweep in progress.
- collision  out  1  one-cycle pulse: both ports wrote the same address with overlapping byte enables.

## Operation
- A request is accepted when req && ready. Requests presented while ready = 0 are dropped: no write, no rvalid. Requests are not queued.
- ready = ~busy for both ports. With no clear sweep, ready = 1 whenever reset is low.
- Reads: rdata is loaded at the accepting edge. rvalid is 1 for the following cycle only. rdata holds its value until the next accepted read on that port. Writes never pulse rvalid.
- Writes: each byte i with be[i] = 1 is updated. be = 0 is a legal no-op.
- Read on one port and write to the same address on the other port in the same cycle: the reader returns the merged new word, i.e. the writer's enabled bytes plus the old memory bytes elsewhere.
- Both ports write the same address in the same cycle: port A wins on bytes both ports enable. Bytes enabled by only one port take that port's data. collision pulses for one cycle when the byte enables overlap.
- Address range is exact (power-of-two DEPTH); no wrap logic needed.
- Clear FSM (only with SPM_CLEAR_EN):
  - States: CLEAR, RUN. Reset forces CLEAR and sets the clear counter to 0.
  - In CLEAR, each cycle writes 0 to word[counter] and increments the counter.
  - When counter = DEPTH−1 has been written, the FSM moves to RUN. The counter wraps to 0 unused.
  - RUN is terminal until the next reset.
- Reset values: a_rdata = b_rdata = 0, a_rvalid = b_rvalid = 0, collision = 0. busy = 1 with SPM_CLEAR_EN, 0 without. Memory contents are not reset by reset itself.
- Reset asserted mid-sweep aborts the sweep. After release the sweep restarts from address 0.

## Timing
- Read latency: 1 cycle from the accepting edge to valid rdata/rvalid.
- Write becomes visible to a read on either port accepted on the next edge. The same edge is also covered, via the merge rule above.
- Clear sweep: busy = 1 from reset assertion through the DEPTH-th rising edge after reset release. ready = 1 in the cycle after that edge. Total DEPTH cycles of unavailability.
- Back-to-back requests every cycle are sustained on both ports simultaneously.

## Configuration
- SPM_CLEAR_EN defined: clear FSM, counter and busy logic are present. Memory reads 0 everywhere after the sweep.
- SPM_CLEAR_EN undefined: no FSM. busy is tied 0, ready is tied 1 outside reset, and memory is uninitialised (X in simulation).

## Structure
- Shared package spm_pkg holds:
  - default DATA_W/DEPTH constants;
  - the clear FSM state typedef (CLEAR, RUN);
  - a byte-merge function (old, new, be) → word.
- Sub-module spm_dpram_port is natural: request acceptance, rdata/rvalid register and merge selection for one port. It is instantiated for A and B. The memory array, write arbitration and clear FSM stay in the top.

## Test plan
- Clear sweep (SPM_CLEAR_EN, DEPTH = 16):
  - busy = 1 for exactly 16 cycles after reset release; ready rises on cycle 17.
  - A read of every address returns 0.
- A writes 0xDEADBEEF to address 5 with be = 4'b1111, then A writes be = 4'b0001 data 0x000000AA. B reads address 5 → 0xDEADBEAA, with b_rvalid high exactly one cycle after acceptance.
- Same cycle on address 3 (old value 0x11223344): A reads, B writes 0xAABBCCDD with be = 4'b0011 → a_rdata = 0x1122CCDD.
- Same cycle, same address 7: A writes 0x11111111 with be = 4'b0110; B writes 0x22222222 with be = 4'b1100. Expect collision = 1 for one cycle; a later read → 0x22111100 on a zeroed word.
- Reset asserted at sweep cycle 8: outputs return to reset values immediately; after release busy lasts a full 16 cycles again.
- Requests with req = 1 while busy = 1 → no rvalid; memory unchanged after the sweep completes.
